// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous frame-buffer RAM between VGA scan-out
// and a pixel writer (CPU or drawing engine). Display fetches own the RAM on
// every pixel-strobe cycle inside the visible window. Every other cycle is
// offered to the writer through a valid/ready handshake.
//
// Ports:
//   clk            single clock
//   i_rst_n        asynchronous active-low reset
//   i_pxen         pixel-strobe clock enable
//   i_haddr_en     horizontal visible window
//   i_vaddr_en     vertical visible window
//   i_hidx         column within the visible area
//   i_vidx         line within the visible area
//   i_wr_valid     writer request
//   i_wr_addr      writer linear pixel address
//   i_wr_data      writer pixel value
//   o_wr_ready     writer request accepted this cycle (combinational)
//   o_mem_addr     RAM address (registered)
//   o_mem_we       RAM write enable (registered, one-cycle pulse)
//   o_mem_wdata    RAM write data (registered)
//   i_mem_rdata    RAM read data, valid one cycle after the address edge
//   o_px_data      pixel to the DAC stage, 0 when no fetched pixel
//   o_px_valid     o_px_data carries a fetched pixel
//   o_frame_start  one-cycle pulse after i_vaddr_en rises
//   o_wr_err       sticky flag: writer addressed beyond the frame
//   i_stat_clr     synchronous clear of o_wr_err and o_wr_stall
//   o_wr_stall     saturating count of cycles the writer was held off
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_BIT  = 19,
    parameter int DATA_BIT  = 8,
    parameter int STALL_BIT = 16
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_pxen,
    input  logic                 i_haddr_en,
    input  logic                 i_vaddr_en,
    input  logic [9:0]           i_hidx,
    input  logic [8:0]           i_vidx,
    input  logic                 i_wr_valid,
    input  logic [ADDR_BIT-1:0]  i_wr_addr,
    input  logic [DATA_BIT-1:0]  i_wr_data,
    output logic                 o_wr_ready,
    output logic [ADDR_BIT-1:0]  o_mem_addr,
    output logic                 o_mem_we,
    output logic [DATA_BIT-1:0]  o_mem_wdata,
    input  logic [DATA_BIT-1:0]  i_mem_rdata,
    output logic [DATA_BIT-1:0]  o_px_data,
    output logic                 o_px_valid,
    output logic                 o_frame_start,
    output logic                 o_wr_err,
    input  logic                 i_stat_clr,
    output logic [STALL_BIT-1:0] o_wr_stall
);

    // Owner of the RAM port for the current cycle.
    typedef enum logic [1:0] {
        GRANT_IDLE  = 2'd0,
        GRANT_DISP  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_t;

    // One extra bit so the compare still works when the frame exactly fills
    // the address space.
    localparam logic [ADDR_BIT:0]    FRAME_PIXELS = (ADDR_BIT+1)'(H_VISIBLE * V_VISIBLE);
    localparam logic [STALL_BIT-1:0] STALL_MAX    = '1;

    logic                disp_req;
    grant_t              grant;
    logic [ADDR_BIT-1:0] disp_addr;
    logic                wr_in_range;
    logic                wr_stalled;
    logic                wr_bad_addr;
    logic                rd_valid1;
    logic                rd_valid2;
    logic                vaddr_en_q;

    // A display fetch is needed only on a pixel strobe inside both windows.
    assign disp_req = i_pxen & i_haddr_en & i_vaddr_en;

    // Fixed-priority grant: the display can never be delayed, so the writer
    // only gets cycles the display does not need.
    always_comb begin
        grant = GRANT_IDLE;
        if (disp_req) begin
            grant = GRANT_DISP;
        end else if (i_wr_valid) begin
            grant = GRANT_WRITE;
        end
    end

    // Ready is held low throughout reset so no write can slip in while the
    // registers are being cleared.
    assign o_wr_ready = i_rst_n & ~disp_req;

    // Linear frame-buffer address of the pixel under the beam, computed at
    // full RAM address width so the largest in-frame index cannot wrap.
    assign disp_addr = ADDR_BIT'(i_vidx) * ADDR_BIT'(H_VISIBLE) + ADDR_BIT'(i_hidx);

    assign wr_in_range = ({1'b0, i_wr_addr} < FRAME_PIXELS);
    assign wr_stalled  = i_wr_valid & ~o_wr_ready;
    assign wr_bad_addr = (grant == GRANT_WRITE) & ~wr_in_range;

    // RAM command register. A write beyond the frame is still accepted by the
    // handshake but never reaches the RAM; the address and data registers
    // simply keep their previous contents in that case and on idle cycles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_we <= 1'b0;
            case (grant)
                GRANT_DISP: begin
                    o_mem_addr <= disp_addr;
                end
                GRANT_WRITE: begin
                    if (wr_in_range) begin
                        o_mem_addr  <= i_wr_addr;
                        o_mem_wdata <= i_wr_data;
                        o_mem_we    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky out-of-range flag. A clear in the same cycle as a new error wins.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_err <= 1'b0;
        end else if (i_stat_clr) begin
            o_wr_err <= 1'b0;
        end else if (wr_bad_addr) begin
            o_wr_err <= 1'b1;
        end
    end

    // Counts cycles the writer waited behind the display, saturating so a
    // long-running stall never wraps back to a small value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_stall <= '0;
        end else if (i_stat_clr) begin
            o_wr_stall <= '0;
        end else if (wr_stalled && (o_wr_stall != STALL_MAX)) begin
            o_wr_stall <= o_wr_stall + 1'b1;
        end
    end

    // Read pipeline: stage 1 lines up with the address on the RAM port,
    // stage 2 with the returning read data, which is then registered into the
    // pixel output. Reset empties every stage so fetches in flight are
    // dropped rather than emitted after reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid1  <= 1'b0;
            rd_valid2  <= 1'b0;
            o_px_valid <= 1'b0;
            o_px_data  <= '0;
        end else begin
            rd_valid1  <= (grant == GRANT_DISP);
            rd_valid2  <= rd_valid1;
            o_px_valid <= rd_valid2;
            o_px_data  <= rd_valid2 ? i_mem_rdata : '0;
        end
    end

    // Frame-start pulse from the rising edge of the vertical window. The
    // registered copy starts at 0, so a window already open when reset
    // releases also marks the start of a frame.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vaddr_en_q    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            vaddr_en_q    <= i_vaddr_en;
            o_frame_start <= i_vaddr_en & ~vaddr_en_q;
        end
    end

endmodule
